// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder slice plus a carry flop, one sum bit per clock.
// Optional subtract support is compiled in when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             c_reg, c_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             sum_bit;
    logic             carry_bit;
    logic             cmsb;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as A + ~B + 1; the caller's carry-in is ignored.
    assign b_load = sub ? ~B : B;
    assign c_load = sub ? 1'b1 : Cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = B;
    assign c_load     = Cin;
`endif

    assign sum_bit   = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign carry_bit = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);
    // On the last RUN edge the carry flop still holds the carry into the MSB.
    assign cmsb      = c_reg;

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        c_next     = c_reg;
        cnt_next   = cnt_reg;
        s_next     = s_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = A;
                    b_next     = b_load;
                    c_next     = c_load;
                    cnt_next   = '0;
                    sum_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next   = a_reg >> 1;
                b_next   = b_reg >> 1;
                c_next   = carry_bit;
                sum_next = {sum_bit, sum_reg[WIDTH-1:1]};
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    s_next     = {sum_bit, sum_reg[WIDTH-1:1]};
                    cout_next  = carry_bit;
                    ovf_next   = cmsb ^ carry_bit;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            c_reg     <= 1'b0;
            cnt_reg   <= '0;
            s_reg     <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            c_reg     <= c_next;
            cnt_reg   <= cnt_next;
            s_reg     <= s_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign S    = s_reg;
    assign Cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule
